// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer request/data bus and FIFO write port of the write arbiter.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ*DATA_WIDTH-1:0] wdata_in;
    logic                        fifo_full;
    logic [N_REQ-1:0]            gnt;
    logic [N_REQ-1:0]            ack;
    logic                        fifo_wr;
    logic [DATA_WIDTH-1:0]       fifo_wdata;
    logic                        busy;

    modport master (
        input  req, wdata_in, fifo_full,
        output gnt, ack, fifo_wr, fifo_wdata, busy
    );

    modport slave (
        output req, wdata_in, fifo_full,
        input  gnt, ack, fifo_wr, fifo_wdata, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port between N_REQ producers.
// FIFO_ARB_HIPRI0_EN gives requester 0 absolute priority and leaves ptr alone after its bursts.
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input logic clk,
    input logic reset,
    fifo_wr_arbiter_if.master bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [PW:0]   NR   = (PW+1)'(N_REQ);
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nxt;
    logic [N_REQ-1:0]   gnt_q, gnt_nxt;
    logic [PW-1:0]      gidx, gidx_nxt;
    logic [PW-1:0]      ptr, ptr_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [PW-1:0]      off, win, gnext;
    logic [PW:0]        sum;
    logic               req_g, accept, done;

    // Rotate requests so ptr sits at bit 0, find the lowest set bit, then rotate back.
    always_comb begin
        dbl = {bus.req, bus.req} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot[i]) off = PW'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        win = (sum >= NR) ? PW'(sum - NR) : sum[PW-1:0];
`ifdef FIFO_ARB_HIPRI0_EN
        win = bus.req[0] ? '0 : win;
`endif
    end

    assign req_g  = bus.req[gidx];
    assign accept = (state == GRANT) & req_g & ~bus.fifo_full;
    assign done   = ~req_g | (accept & (cnt == LAST));
    assign gnext  = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt_q <= '0;
            gidx  <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt_q <= gnt_nxt;
            gidx  <= gidx_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        gidx_nxt  = gidx;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        if (state == IDLE) begin
            if (|bus.req) begin
                state_nxt = GRANT;
                gnt_nxt   = N_REQ'(1) << win;
                gidx_nxt  = win;
                cnt_nxt   = '0;
            end
        end else if (done) begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            cnt_nxt   = '0;
`ifdef FIFO_ARB_HIPRI0_EN
            ptr_nxt   = (gidx == '0) ? ptr : gnext;
`else
            ptr_nxt   = gnext;
`endif
        end else if (accept) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.busy       = (state == GRANT);
    assign bus.fifo_wr    = accept;
    assign bus.ack        = accept ? gnt_q : '0;
    assign bus.fifo_wdata = (state == GRANT) ? bus.wdata_in[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized bench comparing the arbiter against a burst-level reference model.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    int tests = 0;
    int fails = 0;
    int seq[N];
    int rem[N];
    logic [N-1:0] en;
    int mg = -1;
    int mptr = 0;
    int mcnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive producers, check outputs against the model, advance the model.
    task automatic step(input logic f);
        logic [N-1:0] r;
        logic acc;
        logic [31:0] eg, ed;
        int w;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            r[i] = (rem[i] > 0) && en[i];
            bus.wdata_in[i*DW +: DW] = {4'(i), 12'(seq[i])};
        end
        bus.req = r;
        bus.fifo_full = f;
        #1;
        acc = (mg >= 0) && r[mg] && !f;
        eg = (mg >= 0) ? (32'd1 << mg) : 32'd0;
        ed = (mg >= 0) ? {16'd0, 4'(mg), 12'(seq[mg])} : 32'd0;
        check("gnt", 32'(bus.gnt), eg);
        check("ack", 32'(bus.ack), acc ? eg : 32'd0);
        check("fifo_wr", 32'(bus.fifo_wr), 32'(acc));
        check("fifo_wdata", 32'(bus.fifo_wdata), ed);
        check("busy", 32'(bus.busy), 32'(mg >= 0));
        if (mg < 0) begin
            if (r != '0) begin
                w = -1;
                for (int k = N - 1; k >= 0; k--)
                    if (r[(mptr + k) % N]) w = (mptr + k) % N;
`ifdef FIFO_ARB_HIPRI0_EN
                if (r[0]) w = 0;
`endif
                mg = w;
                mcnt = 0;
            end
        end else begin
            if (acc) begin
                seq[mg]++;
                rem[mg]--;
                mcnt++;
            end
            if (!r[mg] || mcnt == MB) begin
`ifdef FIFO_ARB_HIPRI0_EN
                if (mg != 0) mptr = (mg + 1) % N;
`else
                mptr = (mg + 1) % N;
`endif
                mg = -1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req = '0;
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_wr", 32'(bus.fifo_wr), 32'd0);
        check("rst_wdata", 32'(bus.fifo_wdata), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        mg = -1;
        mptr = 0;
        mcnt = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.req = '0;
        bus.wdata_in = '0;
        bus.fifo_full = 1'b0;
        en = '0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            rem[i] = 0;
        end
        do_reset();
        // single requester, two bursts
        en = 4'b0010; rem[1] = 6;
        repeat (12) step(1'b0);
        // all requesting: rotation
        en = 4'b1111;
        for (int i = 0; i < N; i++) rem[i] = 8;
        repeat (45) step(1'b0);
        for (int i = 0; i < N; i++) rem[i] = 0;
        repeat (6) step(1'b0);
        // backpressure on requester 2 after its second write
        en = 4'b0100; rem[2] = 4;
        repeat (3) step(1'b0);
        repeat (3) step(1'b1);
        repeat (5) step(1'b0);
        // early release by requester 3, requester 0 pending
        en = 4'b1001; rem[3] = 2; rem[0] = 3;
        repeat (10) step(1'b0);
        // reset mid-burst, then requester 2 alone
        en = 4'b0010; rem[1] = 3;
        repeat (2) step(1'b0);
        do_reset();
        en = 4'b0100; rem[2] = 2;
        repeat (5) step(1'b0);
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 350) do_reset();
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom % 6 == 0) rem[i] = int'($urandom_range(1, 9));
                en[i] = ($urandom % 10) != 0;
            end
            step(($urandom % 4) == 0);
        end
        en = '1;
        repeat (200) step(1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the asymmetric FIFO between N_REQ producers.
- Grants one requester at a time for a burst of up to MAX_BURST words.
- Honours FIFO full backpressure and rotates priority after each burst.
- Sits between producer blocks and the FIFO write port: fifo_wr drives wr, fifo_wdata drives the FIFO's wide write data.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 16, width of one write word (two FIFO read entries).
- MAX_BURST, 4, maximum words accepted per grant (1..16).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester write request; bit i held high while requester i has a word on wdata_in slice i.
- wdata_in  input  N_REQ*DATA_WIDTH  packed request data; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- fifo_full  input  1  FIFO full flag.
- gnt  output  N_REQ  registered one-hot grant; all zero when idle.
- ack  output  N_REQ  per-requester word-accepted strobe (combinational); requester i advances its data on ack[i].
- fifo_wr  output  1  write strobe to FIFO.
- fifo_wdata  output  DATA_WIDTH  muxed data of the granted requester; zero when no grant.
- busy  output  1  high while in GRANT state.

Behaviour:
- Reset values:
  - gnt=0, ack=0, fifo_wr=0, fifo_wdata=0, busy=0.
  - state=IDLE, priority pointer ptr=0, burst count cnt=0.
- States: IDLE, GRANT.
- IDLE:
  - If any req is high, choose the winner: the first index at or after ptr with req high, searching ptr, ptr+1, ... wrapping mod N_REQ.
  - Register gnt=onehot(winner), cnt=0, go to GRANT.
  - If no req is high, stay in IDLE.
  - No write ever occurs in IDLE. Arbitration latency is 1 cycle: req rising in cycle k gives gnt in cycle k+1 and the first possible write in cycle k+1.
- GRANT (granted index g):
  - accept = req[g] & ~fifo_full.
  - fifo_wr = accept, ack[g] = accept, fifo_wdata = slice g.
  - On accept, cnt increments.
- GRANT exits to IDLE, with gnt cleared and ptr = (g+1) mod N_REQ, when either:
  - accept and cnt == MAX_BURST-1 (burst exhausted), or
  - req[g] is low (requester released).
- fifo_full while req[g] is high: stall. Grant is held, cnt is unchanged, no ack, no fifo_wr. There is no timeout.
- ack is never asserted for a non-granted requester. Other requesters' req is ignored during GRANT.
- Simultaneous events: req[g] drops in the same cycle the burst would end. Treat this as release; no write occurs; ptr advances.
- Wrap-around: ptr = N_REQ-1 followed by advance gives 0. cnt width is clog2(MAX_BURST)+1 bits and never exceeds MAX_BURST-1.
- Reset mid-burst: everything returns to reset values at once. Any word not yet acked is not written.
- Fairness: every continuously requesting producer is granted within N_REQ-1 bursts.

Optional Feature:
- Macro FIFO_ARB_HIPRI0_EN.
- Defined: in IDLE, if req[0] is high, requester 0 wins regardless of ptr. ptr is not updated after a requester-0 burst; other bursts update ptr as normal.
- Undefined: pure round-robin as described above.

Test Plan:
- Single requester: reset, then req=4'b0010 held with 6 words, fifo_full=0. Required: gnt=0010 one cycle after req; ack/fifo_wr high for 4 cycles with words 1..4; IDLE for 1 cycle; re-grant; words 5..6 written; ptr=2 after each burst.
- Rotation: req=4'b1111 held. Required: grant order 0,1,2,3,0, each burst exactly 4 writes, with one idle cycle between bursts.
- Backpressure: requester 2 granted and fifo_full asserted for 3 cycles after the 2nd write. Required: no fifo_wr and no ack for those 3 cycles; gnt held; burst completes with 4 total writes and no lost or duplicated data.
- Early release: requester 3 drops req after 2 accepted words. Required: exit to IDLE the next edge with 2 writes; ptr wraps to 0; pending req[0] is granted next.
- Reset mid-burst: assert reset after 1 write of a burst. Required: gnt/ack/fifo_wr go to 0 immediately; after release, req=4'b0100 is granted to requester 2 (ptr=0 search).
- Macro FIFO_ARB_HIPRI0_EN: with ptr=2 and req=4'b0101. Required: requester 0 wins; ptr stays 2; requester 2 is granted next.
